// File: rtl/bcd_tick_counter.sv
// Three-digit BCD up/down counter stepped by a prescaled tick, with
// synchronised and debounced pause/direction/clear push-buttons.
module bcd_tick_counter #(
  parameter int unsigned TICK_DIV        = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLK_50,
  input  logic       RST_N,
  input  logic       BTN_PAUSE,
  input  logic       BTN_DIR,
  input  logic       BTN_CLEAR,
  output logic [3:0] BCD0,
  output logic [3:0] BCD1,
  output logic [3:0] BCD2,
  output logic       RUNNING,
  output logic       DIR_DOWN,
  output logic       TICK,
  output logic       WRAP
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);

  localparam int unsigned B_PAUSE = 0;
  localparam int unsigned B_DIR   = 1;
  localparam int unsigned B_CLEAR = 2;

  logic [2:0]          raw;
  logic [2:0]          sync1_q, sync2_q;
  logic [2:0]          deb_q, deb_d;
  logic [2:0]          press;
  logic [2:0][DW-1:0]  dcnt_q, dcnt_d;

  logic [PW-1:0]       presc_q, presc_d;
  logic [2:0][3:0]     dig_q, dig_d, dig_step;
  logic                run_q, run_d;
  logic                dir_q, dir_d;
  logic                tick_q, tick_d;
  logic                wrap_q, wrap_d;
  logic                step;
  logic                cy;

  assign raw = {BTN_CLEAR, BTN_DIR, BTN_PAUSE};

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] + DW'(1) == DMAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Press = debounced level falling in this cycle; release edges are ignored.
  assign press = deb_q & ~deb_d;
  assign step  = run_q && (presc_q == PMAX);

  // Ripple carry/borrow across the digits; carry out of the top digit is the wrap.
  always_comb begin
    dig_step = dig_q;
    cy       = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      if (cy) begin
        if (!dir_q) begin
          if (dig_q[i] == 4'd9) begin
            dig_step[i] = 4'd0;
          end else begin
            dig_step[i] = dig_q[i] + 4'd1;
            cy          = 1'b0;
          end
        end else begin
          if (dig_q[i] == 4'd0) begin
            dig_step[i] = 4'd9;
          end else begin
            dig_step[i] = dig_q[i] - 4'd1;
            cy          = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    presc_d = presc_q;
    dig_d   = dig_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (press[B_CLEAR]) begin
      presc_d = '0;
      dig_d   = '0;
    end else if (step) begin
      presc_d = '0;
      dig_d   = dig_step;
      tick_d  = 1'b1;
      wrap_d  = cy;
    end else if (run_q) begin
      presc_d = presc_q + PW'(1);
    end
    run_d = run_q ^ press[B_PAUSE];
    dir_d = dir_q ^ press[B_DIR];
  end

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      dcnt_q  <= '0;
      presc_q <= '0;
      dig_q   <= '0;
      run_q   <= 1'b1;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      presc_q <= presc_d;
      dig_q   <= dig_d;
      run_q   <= run_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign BCD0     = dig_q[0];
  assign BCD1     = dig_q[1];
  assign BCD2     = dig_q[2];
  assign RUNNING  = run_q;
  assign DIR_DOWN = dir_q;
  assign TICK     = tick_q;
  assign WRAP     = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench: every cycle compares the DUT against an integer-count
// reference model driven by directed and random button stimulus.
module tb_bcd_tick_counter;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       CLK_50 = 1'b0;
  logic       RST_N;
  logic       btn_pause, btn_dir, btn_clear;
  logic [3:0] BCD0, BCD1, BCD2;
  logic       RUNNING, DIR_DOWN, TICK, WRAP;

  bcd_tick_counter #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK_50   (CLK_50),
    .RST_N    (RST_N),
    .BTN_PAUSE(btn_pause),
    .BTN_DIR  (btn_dir),
    .BTN_CLEAR(btn_clear),
    .BCD0     (BCD0),
    .BCD1     (BCD1),
    .BCD2     (BCD2),
    .RUNNING  (RUNNING),
    .DIR_DOWN (DIR_DOWN),
    .TICK     (TICK),
    .WRAP     (WRAP)
  );

  always #5 CLK_50 = ~CLK_50;

  int errors = 0;
  int checks = 0;

  // Reference model state: count held as a plain integer 0..999.
  int m_s1[3], m_s2[3], m_deb[3], m_cnt[3];
  int m_count, m_presc, m_run, m_dir, m_tick, m_wrap;
  int clr_step_seen = 0;
  int wrap_seen = 0;
  int hold[3];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dut_val();
    return int'(BCD2) * 100 + int'(BCD1) * 10 + int'(BCD0);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_s1[b] = 1; m_s2[b] = 1; m_deb[b] = 1; m_cnt[b] = 0;
    end
    m_count = 0; m_presc = 0; m_run = 1; m_dir = 0; m_tick = 0; m_wrap = 0;
  endtask

  task automatic model_update();
    int ev[3];
    int raw[3];
    int stp;
    raw[0] = int'(btn_pause); raw[1] = int'(btn_dir); raw[2] = int'(btn_clear);
    for (int b = 0; b < 3; b++) begin
      ev[b] = 0;
      if (m_s2[b] != m_deb[b]) begin
        if (m_cnt[b] + 1 >= DB) begin
          if (m_deb[b] == 1) ev[b] = 1;
          m_deb[b] = m_s2[b];
          m_cnt[b] = 0;
        end else begin
          m_cnt[b]++;
        end
      end else begin
        m_cnt[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    stp = (m_run != 0 && m_presc == TD - 1) ? 1 : 0;
    m_tick = 0;
    m_wrap = 0;
    if (ev[2] != 0) begin
      m_count = 0;
      m_presc = 0;
      if (stp != 0) clr_step_seen++;
    end else if (stp != 0) begin
      m_presc = 0;
      m_tick  = 1;
      if (m_dir == 0) begin
        if (m_count == 999) m_wrap = 1;
        m_count = (m_count + 1) % 1000;
      end else begin
        if (m_count == 0) m_wrap = 1;
        m_count = (m_count + 999) % 1000;
      end
    end else if (m_run != 0) begin
      m_presc++;
    end
    if (ev[0] != 0) m_run = 1 - m_run;
    if (ev[1] != 0) m_dir = 1 - m_dir;
  endtask

  task automatic check_all();
    check_eq("bcd0", int'(BCD0), m_count % 10);
    check_eq("bcd1", int'(BCD1), (m_count / 10) % 10);
    check_eq("bcd2", int'(BCD2), m_count / 100);
    check_eq("running", int'(RUNNING), m_run);
    check_eq("dir_down", int'(DIR_DOWN), m_dir);
    check_eq("tick", int'(TICK), m_tick);
    check_eq("wrap", int'(WRAP), m_wrap);
    if (WRAP) wrap_seen++;
  endtask

  task automatic cycle();
    @(posedge CLK_50);
    model_update();
    @(negedge CLK_50);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_pause = v;
      1: btn_dir   = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic press(input int b, input int len);
    set_btn(b, 1'b0);
    run(len);
    set_btn(b, 1'b1);
  endtask

  task automatic wait_count(input int target, input int budget);
    int n = 0;
    while (m_count != target && n < budget) begin
      cycle();
      n++;
    end
    check_eq("reach_count", dut_val(), target);
  endtask

  task automatic wait_presc(input int p);
    int n = 0;
    while (m_presc != p && n < 16) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    btn_pause = 1'b1; btn_dir = 1'b1; btn_clear = 1'b1;
    RST_N = 1'b0;
    for (int b = 0; b < 3; b++) hold[b] = 0;
    model_reset();
    repeat (2) @(negedge CLK_50);
    check_all();
    RST_N = 1'b1;

    // Free run: ten steps in 40 cycles.
    run(40);
    check_eq("ten_ticks", dut_val(), 10);

    // Up-count wrap 999 -> 000.
    wait_count(998, 5000);
    run(8);
    check_eq("after_wrap_up", dut_val(), 0);

    // Direction change at 001, then down-wrap 000 -> 999 -> 998.
    wait_count(1, 100);
    press(1, 10);
    check_eq("dir_now_down", int'(DIR_DOWN), 1);
    run(20);

    // Short pause glitch, then a real pause/resume.
    press(0, 2);
    run(10);
    check_eq("glitch_no_pause", int'(RUNNING), 1);
    wait_presc(2);
    press(0, 10);
    check_eq("paused", int'(RUNNING), 0);
    run(50);
    press(0, 10);
    run(20);

    // Clear pressed at each prescaler phase so one lands on a step strobe.
    for (int off = 0; off < TD; off++) begin
      wait_presc(off);
      press(2, 6);
      run(10);
    end
    check_eq("clear_on_step_hit", (clr_step_seen > 0) ? 1 : 0, 1);

    // Random button activity, including sub-debounce glitches.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0 && $urandom_range(0, 24) == 0) hold[b] = int'($urandom_range(1, 8));
        set_btn(b, (hold[b] > 0) ? 1'b0 : 1'b1);
      end
      cycle();
      for (int b = 0; b < 3; b++) if (hold[b] > 0) hold[b]--;
    end
    btn_pause = 1'b1; btn_dir = 1'b1; btn_clear = 1'b1;
    run(10);

    // Asynchronous reset mid-period while counting down and paused.
    if (m_run == 0) press(0, 6);
    if (m_dir == 0) press(1, 6);
    run(30);
    press(0, 6);
    run(5);
    #2 RST_N = 1'b0;
    #1;
    check_eq("rst_bcd", dut_val(), 0);
    check_eq("rst_running", int'(RUNNING), 1);
    check_eq("rst_dir", int'(DIR_DOWN), 0);
    check_eq("rst_tick", int'(TICK), 0);
    check_eq("rst_wrap", int'(WRAP), 0);
    model_reset();
    @(negedge CLK_50);
    check_all();
    @(negedge CLK_50);
    check_all();
    RST_N = 1'b1;
    run(41);
    check_eq("restart_up", dut_val(), 10);
    check_eq("wrap_seen", (wrap_seen > 0) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
